sdio_reg_master: RTL and testbench

SDIO_REG_MASTER -- requirements
Module: sdio_reg_master

---
 rtl/sdio_reg_master.sv | 169 ++++++++++++++++
 tb/tb_sdio_reg_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_reg_master.sv
// Byte-serial register master: 1-4 byte bursts, 3 cycles per written byte (4 with SDIO_REG_MASTER_RDBACK_EN), 2 per read byte.
// One request in flight; req_ready low until the response is taken, and the response is held while rsp_ready is low.
module sdio_reg_master (
    input  logic        sys_clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        reg_wr,
    output logic [7:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] W_SETUP = 3'd1;
    localparam logic [2:0] W_STRB  = 3'd2;
    localparam logic [2:0] W_HOLD  = 3'd3;
`ifdef SDIO_REG_MASTER_RDBACK_EN
    localparam logic [2:0] W_CMP   = 3'd4;
`endif
    localparam logic [2:0] R_ADDR  = 3'd5;
    localparam logic [2:0] R_CAP   = 3'd6;
    localparam logic [2:0] RESP    = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  reg_wdata_q, reg_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        reg_wr_q, req_ready_q, rsp_valid_q, busy_q;
`ifdef SDIO_REG_MASTER_RDBACK_EN
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        rdata_d     = rdata_q;
`ifdef SDIO_REG_MASTER_RDBACK_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    len_d      = req_len;
                    wdata_d    = req_wdata;
                    idx_d      = 2'd0;
                    reg_addr_d = req_addr;
                    rdata_d    = 32'h0;
`ifdef SDIO_REG_MASTER_RDBACK_EN
                    err_d      = 1'b0;
`endif
                    if (req_write) begin
                        reg_wdata_d = req_wdata[7:0];
                        state_d     = W_SETUP;
                    end else begin
                        state_d     = R_ADDR;
                    end
                end
            end
            W_SETUP: state_d = W_STRB;
            W_STRB:  state_d = W_HOLD;
`ifdef SDIO_REG_MASTER_RDBACK_EN
            W_HOLD:  state_d = W_CMP;
            W_CMP: begin
                if (reg_rdata != reg_wdata_q) err_d = 1'b1;
                if (idx_q == len_q) begin
                    state_d = RESP;
                end else begin
                    idx_d       = idx_q + 2'd1;
                    reg_addr_d  = reg_addr_q + 8'd1;
                    reg_wdata_d = wdata_q[{idx_d, 3'b000} +: 8];
                    state_d     = W_SETUP;
                end
            end
`else
            W_HOLD: begin
                if (idx_q == len_q) begin
                    state_d = RESP;
                end else begin
                    idx_d       = idx_q + 2'd1;
                    reg_addr_d  = reg_addr_q + 8'd1;
                    reg_wdata_d = wdata_q[{idx_d, 3'b000} +: 8];
                    state_d     = W_SETUP;
                end
            end
`endif
            R_ADDR:  state_d = R_CAP;
            R_CAP: begin
                rdata_d[{idx_q, 3'b000} +: 8] = reg_rdata;
                if (idx_q == len_q) begin
                    state_d = RESP;
                end else begin
                    idx_d      = idx_q + 2'd1;
                    reg_addr_d = reg_addr_q + 8'd1;
                    state_d    = R_ADDR;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            len_q       <= 2'd0;
            wdata_q     <= 32'h0;
            reg_addr_q  <= 8'h0;
            reg_wdata_q <= 8'h0;
            rdata_q     <= 32'h0;
            reg_wr_q    <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SDIO_REG_MASTER_RDBACK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            rdata_q     <= rdata_d;
            reg_wr_q    <= (state_d == W_STRB);
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            busy_q      <= (state_d != IDLE);
`ifdef SDIO_REG_MASTER_RDBACK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign reg_wr    = reg_wr_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign busy      = busy_q;
`ifdef SDIO_REG_MASTER_RDBACK_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sdio_reg_master.sv
// Scoreboard bench for sdio_reg_master: directed bursts, expected strobes and responses queued, monitors compare.
module tb_sdio_reg_master;

    logic        sys_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = 8'h0;
    logic [1:0]  req_len = 2'd0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        reg_wr;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        busy;

    sdio_reg_master dut (
        .sys_clk(sys_clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

`ifdef SDIO_REG_MASTER_RDBACK_EN
    localparam int  GAP = 4;
    localparam logic ERR_ON_MISMATCH = 1'b1;
`else
    localparam int  GAP = 3;
    localparam logic ERR_ON_MISMATCH = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        exp_rsp[$];
    logic [15:0] exp_wr[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr = -1;

    // Register block model: 0 = addr^A5, 1 = constant, 2 = memory written one cycle after the strobe.
    int         rd_mode = 0;
    logic [7:0] rd_const = 8'h00;
    logic [7:0] mem [256];
    logic       wr_d1 = 1'b0;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    always_comb begin
        reg_rdata = reg_addr ^ 8'hA5;
        if (rd_mode == 1) reg_rdata = rd_const;
        else if (rd_mode == 2) reg_rdata = mem[reg_addr];
    end

    always @(posedge sys_clk) begin
        cyc++;
        if (wr_d1) mem[reg_addr] = reg_wdata;
        wr_d1 = reg_wr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    always @(negedge sys_clk) begin
        if (rstn && rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) fail_evt("unexpected_response");
            else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
            end
        end
        if (rstn && reg_wr) begin
            if (exp_wr.size() == 0) fail_evt("unexpected_reg_wr");
            else chk("reg_wr_addr_data", {16'h0, reg_addr, reg_wdata}, {16'h0, exp_wr.pop_front()});
            if (last_wr >= 0) chk("reg_wr_gap", cyc - last_wr, GAP);
            last_wr = cyc;
        end
        if (!busy) last_wr = -1;
    end

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [1:0] len, input logic [31:0] wd);
        int n;
        @(posedge sys_clk); #1;
        req_write = wr; req_addr = addr; req_len = len; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge sys_clk); #1;
            n++;
        end
        if (!req_ready) fail_evt("req_accept_timeout");
        else begin
            @(posedge sys_clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge sys_clk);
        while ((busy || rsp_valid) && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (busy || rsp_valid) fail_evt("idle_timeout");
    endtask

    task automatic push_rsp(input logic [31:0] rd, input logic er);
        rsp_t e;
        e.rdata = rd;
        e.err   = er;
        exp_rsp.push_back(e);
    endtask

    initial begin
        int acc;
        int n;
        #12;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
        chk("rst_reg_wr",    {31'h0, reg_wr}, 32'h0);
        chk("rst_reg_addr",  {24'h0, reg_addr}, 32'h0);
        chk("rst_reg_wdata", {24'h0, reg_wdata}, 32'h0);
        chk("rst_busy",      {31'h0, busy}, 32'h0);
        rstn = 1'b1;

        // 4-byte write burst
        exp_wr.push_back(16'h0478); exp_wr.push_back(16'h0556);
        exp_wr.push_back(16'h0634); exp_wr.push_back(16'h0712);
        push_rsp(32'h0, 1'b0);
        rd_mode = 2;
        issue(1'b1, 8'h04, 2'd3, 32'h12345678);
        wait_idle();

        // 4-byte read wrapping 0xFF -> 0x00
        rd_mode = 0;
        push_rsp(32'hA4A55A5B, 1'b0);
        issue(1'b0, 8'hFE, 2'd3, 32'h0);
        wait_idle();

        // 2-byte read: upper bytes must be cleared
        push_rsp(32'h0000B4B5, 1'b0);
        issue(1'b0, 8'h10, 2'd1, 32'h0);
        wait_idle();

        // single-byte read latency
        rd_mode = 1; rd_const = 8'h3C;
        push_rsp(32'h0000003C, 1'b0);
        issue(1'b0, 8'h1D, 2'd0, 32'h0);
        acc = cyc;
        n = 0;
        @(negedge sys_clk);
        while (!rsp_valid && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        chk("read_latency", cyc - acc, 2);
        wait_idle();

        // readback mismatch, then matching readback
        rd_mode = 1; rd_const = 8'h01;
        exp_wr.push_back(16'h1C0F);
        push_rsp(32'h0, ERR_ON_MISMATCH);
        issue(1'b1, 8'h1C, 2'd0, 32'h0000000F);
        wait_idle();
        rd_mode = 2;
        exp_wr.push_back(16'h1C0F);
        push_rsp(32'h0, 1'b0);
        issue(1'b1, 8'h1C, 2'd0, 32'h0000000F);
        wait_idle();

        // response stall with an ignored request
        rd_mode = 0;
        rsp_ready = 1'b0;
        push_rsp(32'h00000085, 1'b0);
        issue(1'b0, 8'h20, 2'd0, 32'h0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge sys_clk); #1;
            n++;
        end
        req_write = 1'b1; req_addr = 8'h55; req_len = 2'd2; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("stall_rsp_rdata", rsp_rdata, 32'h00000085);
            chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
        end
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        // reset during the strobe of byte 1 of a write
        exp_wr.push_back(16'h3011); exp_wr.push_back(16'h3122);
        issue(1'b1, 8'h30, 2'd1, 32'h00002211);
        n = 0;
        acc = 0;
        while (acc < 2 && n < 100) begin
            @(negedge sys_clk);
            if (reg_wr) acc++;
            n++;
        end
        if (acc < 2) fail_evt("reset_test_strobe_timeout");
        #2 rstn = 1'b0;
        #1;
        chk("abort_reg_wr", {31'h0, reg_wr}, 32'h0);
        chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        repeat (3) @(posedge sys_clk);
        #1 rstn = 1'b1;
        repeat (10) @(posedge sys_clk);
        #1;
        chk("post_reset_req_ready", {31'h0, req_ready}, 32'h1);

        // wrapping write after reset recovery
        exp_wr.push_back(16'hFFEF); exp_wr.push_back(16'h00BE);
        push_rsp(32'h0, 1'b0);
        issue(1'b1, 8'hFF, 2'd1, 32'h0000BEEF);
        wait_idle();
        repeat (3) @(posedge sys_clk);

        chk("pending_rsp", exp_rsp.size(), 0);
        chk("pending_wr", exp_wr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog");
        $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
